riscv_insn_format_decoder: RTL and testbench

RISCV_INSN_FORMAT_DECODER -- requirements
Module: riscv_insn_format_decoder

---
 rtl/riscv_insn_format_decoder.sv | 167 ++++++++++++++++
 tb/tb_riscv_insn_format_decoder.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_insn_format_decoder.sv
// RV32/RV64 base instruction format decoder: splits a raw word into its fields,
// classifies the format, and buffers the decoded results in a 2-entry FIFO.
module riscv_insn_format_decoder #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       insn,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [6:0]        opcode,
  output logic [4:0]        rd,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [XLEN-1:0]   imm,
  output logic [2:0]        fmt,
  output logic [CNT_W-1:0]  decoded_cnt,
  output logic [CNT_W-1:0]  illegal_cnt
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
  } dec_t;

  dec_t       dec;
  logic [2:0] fmt_c;

  always_comb begin
    fmt_c = FMT_ILL;
    if (insn[1:0] == 2'b11) begin
      case (insn[6:0])
        7'b0110111, 7'b0010111: fmt_c = FMT_U;
        7'b1101111:             fmt_c = FMT_J;
        7'b1100111, 7'b0000011, 7'b0010011,
        7'b0001111, 7'b1110011: fmt_c = FMT_I;
        7'b1100011:             fmt_c = FMT_B;
        7'b0100011:             fmt_c = FMT_S;
        7'b0110011:             fmt_c = FMT_R;
        7'b0011011:             fmt_c = (XLEN == 64) ? FMT_I : FMT_ILL;
        7'b0111011:             fmt_c = (XLEN == 64) ? FMT_R : FMT_ILL;
        default:                fmt_c = FMT_ILL;
      endcase
    end
  end

  // Fields a format does not define stay zero so consumers never see stray bits.
  always_comb begin
    dec        = '0;
    dec.fmt    = fmt_c;
    dec.opcode = insn[6:0];
    case (fmt_c)
      FMT_R: begin
        dec.rd     = insn[11:7];
        dec.rs1    = insn[19:15];
        dec.rs2    = insn[24:20];
        dec.funct3 = insn[14:12];
        dec.funct7 = insn[31:25];
      end
      FMT_I: begin
        dec.rd     = insn[11:7];
        dec.rs1    = insn[19:15];
        dec.funct3 = insn[14:12];
        dec.imm    = XLEN'($signed(insn[31:20]));
      end
      FMT_S: begin
        dec.rs1    = insn[19:15];
        dec.rs2    = insn[24:20];
        dec.funct3 = insn[14:12];
        dec.imm    = XLEN'($signed({insn[31:25], insn[11:7]}));
      end
      FMT_B: begin
        dec.rs1    = insn[19:15];
        dec.rs2    = insn[24:20];
        dec.funct3 = insn[14:12];
        dec.imm    = XLEN'($signed({insn[31], insn[7], insn[30:25], insn[11:8], 1'b0}));
      end
      FMT_U: begin
        dec.rd  = insn[11:7];
        dec.imm = XLEN'($signed({insn[31:12], 12'h000}));
      end
      FMT_J: begin
        dec.rd  = insn[11:7];
        dec.imm = XLEN'($signed({insn[31], insn[19:12], insn[20], insn[30:21], 1'b0}));
      end
      default: ;
    endcase
  end

  // Handshake: a beat moves on a channel at a rising edge where valid && ready
  // are both high; input beats are additionally blocked while flush is high.
  // Valid never depends on ready, and output fields hold while valid && !ready.
  dec_t       mem [2];
  logic       rd_ptr;
  logic       wr_ptr;
  logic [1:0] count;
  logic [1:0] count_nxt;
  logic       push;
  logic       pop;

  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign count_nxt = count + 2'(push) - 2'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem[i]     <= '0;
        mem[i].fmt <= FMT_ILL;
      end
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
      in_ready    <= 1'b0;
      decoded_cnt <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ~wr_ptr;
        decoded_cnt <= decoded_cnt + CNT_W'(1);
        if (dec.fmt == FMT_ILL)
          illegal_cnt <= illegal_cnt + CNT_W'(1);
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count    <= count_nxt;
      in_ready <= (count_nxt != 2'd2);
    end
  end

  assign fmt    = mem[rd_ptr].fmt;
  assign opcode = mem[rd_ptr].opcode;
  assign rd     = mem[rd_ptr].rd;
  assign rs1    = mem[rd_ptr].rs1;
  assign rs2    = mem[rd_ptr].rs2;
  assign funct3 = mem[rd_ptr].funct3;
  assign funct7 = mem[rd_ptr].funct7;
  assign imm    = mem[rd_ptr].imm;

endmodule

// File: tb/tb_riscv_insn_format_decoder.sv
// Directed bench for riscv_insn_format_decoder: hand-decoded vectors, an
// expected-result queue checked on every output handshake, plus a 64-bit instance.
module tb_riscv_insn_format_decoder;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] insn;
  logic        out_ready;
  logic        out_valid;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic [2:0]  fmt;
  logic [15:0] decoded_cnt, illegal_cnt;

  logic        in_ready64, out_valid64;
  logic [6:0]  opcode64;
  logic [4:0]  rd64, rs1_64, rs2_64;
  logic [2:0]  funct3_64;
  logic [6:0]  funct7_64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [2:0]  decoded_cnt64, illegal_cnt64;

  riscv_insn_format_decoder #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .insn(insn), .out_ready(out_ready), .out_valid(out_valid), .opcode(opcode),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
    .fmt(fmt), .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
  );

  riscv_insn_format_decoder #(.XLEN(64), .CNT_W(3)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .insn(insn), .out_ready(out_ready), .out_valid(out_valid64), .opcode(opcode64),
    .rd(rd64), .rs1(rs1_64), .rs2(rs2_64), .funct3(funct3_64), .funct7(funct7_64),
    .imm(imm64), .fmt(fmt64), .decoded_cnt(decoded_cnt64), .illegal_cnt(illegal_cnt64)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [66:0] mk(input logic [2:0] f, input logic [6:0] op,
                                     input logic [4:0] d, input logic [4:0] s1,
                                     input logic [4:0] s2, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] im);
    return {f, op, d, s1, s2, f3, f7, im};
  endfunction

  logic [66:0] obs_v;
  assign obs_v = {fmt, opcode, rd, rs1, rs2, funct3, funct7, imm};

  // ---------------- scoreboard ----------------
  logic [66:0] exp_q[$];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 128'(out_valid), 128'(0));
      else chk("out", 128'(obs_v), 128'(exp_q.pop_front()));
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [66:0] e);
    int n;
    exp_q.push_back(e);
    in_valid = 1'b1;
    insn     = w;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((out_valid || exp_q.size() != 0) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_q_empty", 128'(exp_q.size()), 128'(0));
    chk("drain_out_valid", 128'(out_valid), 128'(0));
  endtask

  // ---------------- vectors (hand decoded) ----------------
  localparam logic [31:0] I_ADD  = 32'h002081B3;  // add x3,x1,x2
  localparam logic [31:0] I_ADDI = 32'hFFF00093;  // addi x1,x0,-1
  localparam logic [31:0] I_BEQ  = 32'hFE000EE3;  // beq x0,x0,-4
  localparam logic [31:0] I_SW   = 32'h0020A423;  // sw x2,8(x1)
  localparam logic [31:0] I_LUI  = 32'h123452B7;  // lui x5,0x12345
  localparam logic [31:0] I_JAL  = 32'hFF9FF0EF;  // jal x1,-8
  localparam logic [31:0] I_SUB  = 32'h402081B3;  // sub x3,x1,x2

  logic [66:0] e_add, e_addi, e_beq, e_sw, e_lui, e_jal, e_sub;
  int c0;

  initial begin
    e_add  = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'h0);
    e_addi = mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF);
    e_beq  = mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC);
    e_sw   = mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'h8);
    e_lui  = mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000);
    e_jal  = mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFF8);
    e_sub  = mk(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0);

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; insn = 32'h0; out_ready = 1'b1;

    // reset values
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_fmt", 128'(fmt), 128'(7));
    chk("rst_fields", 128'(obs_v), 128'(mk(3'd7, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0)));
    chk("rst_cnts", 128'({decoded_cnt, illegal_cnt}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));

    // single R-type, latency 1
    chk("pre_out_valid", 128'(out_valid), 128'(0));
    send(I_ADD, e_add);
    chk("lat1_out_valid", 128'(out_valid), 128'(1));
    wait_drain();

    // I-type, both widths
    send(I_ADDI, e_addi);
    chk("addi_imm64", 128'(imm64), 128'(64'hFFFFFFFFFFFFFFFF));
    chk("addi_fmt64", 128'(fmt64), 128'(1));

    // back-to-back stream at one beat per cycle
    c0 = cyc;
    send(I_BEQ, e_beq);
    send(I_SW, e_sw);
    send(I_LUI, e_lui);
    send(I_JAL, e_jal);
    send(I_SUB, e_sub);
    chk("stream_cycles", 128'(cyc - c0), 128'(5));
    wait_drain();
    chk("stream_dec_cnt", 128'(decoded_cnt), 128'(7));

    // illegal encodings
    send(32'h00000000, mk(3'd7, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0));
    send(32'h0000007F, mk(3'd7, 7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0));
    wait_drain();
    chk("ill_cnt_2", 128'(illegal_cnt), 128'(2));
    send(32'h0000003B, mk(3'd7, 7'h3B, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0));
    chk("addw_fmt64", 128'(fmt64), 128'(0));
    wait_drain();
    chk("ill_cnt_3", 128'(illegal_cnt), 128'(3));
    chk("ill_dec_cnt", 128'(decoded_cnt), 128'(10));
    chk("wrap_dec_cnt64", 128'(decoded_cnt64), 128'(2));
    chk("ill_cnt64", 128'(illegal_cnt64), 128'(2));

    // backpressure: A,B fill, C waits
    out_ready = 1'b0;
    in_valid = 1'b1;
    insn = I_ADD;  exp_q.push_back(e_add);  tick();
    insn = I_ADDI; exp_q.push_back(e_addi); tick();
    chk("full_in_ready", 128'(in_ready), 128'(0));
    insn = I_BEQ;  exp_q.push_back(e_beq);  tick(); tick();
    chk("hold_in_ready", 128'(in_ready), 128'(0));
    chk("hold_head", 128'(obs_v), 128'(e_add));
    chk("hold_dec_cnt", 128'(decoded_cnt), 128'(12));
    out_ready = 1'b1;
    c0 = 0;
    while (!in_ready && c0 < 50) begin
      tick();
      c0++;
    end
    tick();
    in_valid = 1'b0;
    wait_drain();
    chk("bp_dec_cnt", 128'(decoded_cnt), 128'(13));

    // flush drops the buffered entry and the offered beat
    out_ready = 1'b0;
    send(I_LUI, e_lui);
    chk("pre_flush_valid", 128'(out_valid), 128'(1));
    flush = 1'b1; in_valid = 1'b1; insn = 32'h00000000;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    chk("flush_cnts", 128'({decoded_cnt, illegal_cnt}), 128'({16'd14, 16'd3}));
    tick();
    chk("flush_stays_empty", 128'(out_valid), 128'(0));

    // asynchronous reset with a full FIFO
    send(I_JAL, e_jal);
    send(I_SW, e_sw);
    chk("full_before_rst", 128'({out_valid, in_ready}), 128'(2'b10));
    chk("dec_before_rst", 128'(decoded_cnt), 128'(16));
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_in_ready", 128'(in_ready), 128'(0));
    chk("arst_cnts", 128'({decoded_cnt, illegal_cnt}), 128'(0));
    chk("arst_fields", 128'(obs_v), 128'(mk(3'd7, 7'h0, 5'd0, 5'd0, 5'd0, 3'd0, 7'h0, 32'h0)));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rerst_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    send(I_SUB, e_sub);
    wait_drain();
    chk("rerst_dec_cnt", 128'(decoded_cnt), 128'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
